rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of writeback requesters (index 0 ALU, 1 LSU, 2 MDU).
REQ-002 SHALL have port clk  input  1  clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  NREQ  per-requester write request.
REQ-005 SHALL have port req_rd  input  NREQ x 5  per-requester destination register.
REQ-006 SHALL have port req_data  input  NREQ x 32  per-requester write data.
REQ-007 SHALL have port req_ready  output  NREQ  one-hot grant; transfer when valid and ready are both high.
REQ-008 SHALL have port iss_valid  input  1  an instruction with destination is issued this cycle.
REQ-009 SHALL have port iss_rd  input  5  issued destination register.
REQ-010 SHALL have port qa1, qa2  input  5 each  source registers queried for hazard.
REQ-011 SHALL have port stall  output  1  a queried source has a pending write.
REQ-012 SHALL have port wen, waddr, wdata  output  1/5/32  register-file write port.

Function
REQ-013 SHALL grant at most one requester per cycle, round-robin, starting the search at the index after the last granted one.
REQ-014 SHALL drive req_ready combinationally from req_valid and the round-robin pointer; req_ready[i] SHALL never be high while req_valid[i] is low.
REQ-015 SHALL advance the pointer only on a transfer, and set it to the granted index.
REQ-016 SHALL register the granted write: wen/waddr/wdata are valid the cycle after the transfer (1-cycle latency), sustaining one write per cycle.
REQ-017 SHALL accept a request with req_rd = 0, and drive wen = 0 in the following cycle.
REQ-018 SHALL hold a 32-bit busy vector; busy[0] SHALL be constant 0.
REQ-019 SHALL set busy[iss_rd] at the edge where iss_valid is high and iss_rd != 0.
REQ-020 SHALL clear busy[waddr] at the edge where wen is high, i.e. when the register file commits the write.
REQ-021 SHALL give a same-edge set and clear of the same register precedence to the set.
REQ-022 SHALL compute stall combinationally as (qa1 != 0 and busy[qa1]) or (qa2 != 0 and busy[qa2]).
REQ-023 SHALL not forward data; a source is readable the cycle after its busy bit clears.
REQ-024 SHALL keep req_ready at 0 when no request is valid, and SHALL drive wen = 0 in the cycle after.

Reset
REQ-025 SHALL, on rst, clear wen, waddr, wdata and busy to 0, and set the round-robin pointer so that requester 0 has highest priority next.
REQ-026 SHALL force req_ready to 0 while rst is high; stall SHALL read 0 during and after reset until a new issue occurs.
REQ-027 SHALL drop any write pending in the output register when rst is asserted mid-operation; no wen SHALL follow.

Structure
REQ-028 SHALL place NREQ default, requester index constants (REQ_ALU, REQ_LSU, REQ_MDU) and the register-address width in the shared def package.
REQ-029 SHALL implement the round-robin grant as sub-module rr_arbiter (NREQ-wide request, one-hot grant, pointer update on accept).

Verification
REQ-030 Bench SHALL show: all three valid continuously after reset -> grants 0, 1, 2, 0 on successive cycles, wen high each following cycle.
REQ-031 Bench SHALL show: LSU writes rd=5, data 0xDEADBEEF -> next cycle wen=1, waddr=5, wdata=0xDEADBEEF; regfile x5 reads 0xDEADBEEF one cycle later.
REQ-032 Bench SHALL show: issue rd=7, then qa1=7 -> stall=1 until the edge committing the write to x7, then stall=0.
REQ-033 Bench SHALL show: an issue of rd=9 on the same edge that x9's old write commits -> busy[9] stays 1 and stall on qa2=9 remains high.
REQ-034 Bench SHALL show: a request with rd=0, data 0x1234 -> ready=1 and wen=0 next cycle; issue rd=0 then qa1=0 -> stall=0.
REQ-035 Bench SHALL show: rst asserted the cycle after a transfer -> no wen, busy all 0, next grant goes to requester 0.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int unsigned NREQ_DEF = 3;
    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LSU  = 1;
    localparam int unsigned REQ_MDU  = 2;
    localparam int unsigned RA_W     = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NREGS    = 1 << RA_W;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted index.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant_c
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_n;
    logic [PTR_W-1:0] idx;

    // Grant is a pure function of req and ptr; the pointer moves only when something is granted.
    always_comb begin
        grant_c = '0;
        ptr_n   = ptr_q;
        idx     = '0;
        if (!rst) begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx = PTR_W'((32'(ptr_q) + k) % N);
                if (req[idx] && (grant_c == '0)) begin
                    grant_c[idx] = 1'b1;
                    ptr_n        = idx;
                end
            end
        end
    end

    // Reset pointer to the last index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_W'(N - 1);
        end else begin
            ptr_q <= ptr_n;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: round-robin grant into a registered RF write port plus a busy scoreboard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*RA_W-1:0]     req_rd,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     iss_valid,
    input  logic [RA_W-1:0]          iss_rd,
    input  logic [RA_W-1:0]          qa1,
    input  logic [RA_W-1:0]          qa2,
    output logic                     stall,
    output logic                     wen,
    output logic [RA_W-1:0]          waddr,
    output logic [DATA_W-1:0]        wdata
);

    logic [NREQ-1:0]   grant_c;
    logic [RA_W-1:0]   sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_n;

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .grant_c (grant_c)
    );

    assign req_ready = grant_c;

    // One-hot grant lets the payload mux be a plain AND-OR.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                sel_rd   = sel_rd   | req_rd[i*RA_W +: RA_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (grant_c != '0) begin
            wen   <= (sel_rd != '0);
            waddr <= sel_rd;
            wdata <= sel_data;
        end else begin
            wen   <= 1'b0;
        end
    end

    // Set is applied after clear so a same-edge re-issue keeps the register busy.
    always_comb begin
        busy_n = busy_q;
        if (wen) begin
            busy_n[waddr] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_n[iss_rd] = 1'b1;
        end
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_n;
        end
    end

    assign stall = !rst && (((qa1 != '0) && busy_q[qa1]) || ((qa2 != '0) && busy_q[qa2]));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a behavioural scoreboard model.
module tb_rf_wb_arbiter;

    localparam int unsigned NREQ = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_rd;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              iss_valid;
    logic [4:0]        iss_rd;
    logic [4:0]        qa1;
    logic [4:0]        qa2;
    logic              stall;
    logic              wen;
    logic [4:0]        waddr;
    logic [31:0]       wdata;

    int total = 0;
    int bad   = 0;

    bit [31:0] m_busy;
    int        m_last;
    bit        m_wen;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .qa1       (qa1),
        .qa2       (qa2),
        .stall     (stall),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first valid requester strictly after the last granted one.
    function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (v[i]) return NREQ'(1 << i);
        end
        return '0;
    endfunction

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
        req_valid[i]        = 1'b1;
        req_rd[i*5 +: 5]    = rd;
        req_data[i*32 +: 32] = data;
    endtask

    // One cycle: check outputs against the model, then advance the model across the edge.
    task automatic step(input string tag);
        logic [NREQ-1:0] g;
        logic            stall_e;
        logic            seen_wen;
        logic [4:0]      seen_addr;
        logic [31:0]     seen_data;
        int              gi;
        #1;
        g       = rst ? '0 : model_grant(req_valid, m_last);
        stall_e = !rst && (((qa1 != 0) && m_busy[qa1]) || ((qa2 != 0) && m_busy[qa2]));
        check({tag, ".ready"}, 32'(req_ready), 32'(g));
        check({tag, ".stall"}, 32'(stall), 32'(stall_e));
        check({tag, ".wen"}, 32'(wen), 32'(m_wen));
        if (m_wen) begin
            check({tag, ".waddr"}, 32'(waddr), 32'(m_waddr));
            check({tag, ".wdata"}, wdata, m_wdata);
        end
        seen_wen  = wen;
        seen_addr = waddr;
        seen_data = wdata;
        @(posedge clk);
        if (seen_wen === 1'b1) rf[seen_addr] = seen_data;
        if (rst) begin
            m_last  = NREQ - 1;
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_busy  = '0;
        end else begin
            if (m_wen) m_busy[m_waddr] = 1'b0;
            if (iss_valid && (iss_rd != 0)) m_busy[iss_rd] = 1'b1;
            if (g != '0) begin
                gi = 0;
                for (int i = 0; i < NREQ; i++) if (g[i]) gi = i;
                m_last  = gi;
                m_waddr = req_rd[gi*5 +: 5];
                m_wdata = req_data[gi*32 +: 32];
                m_wen   = (m_waddr != 0);
            end else begin
                m_wen = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    logic [NREQ-1:0] rr_exp [4];

    initial begin
        rst = 1'b1; req_valid = '1; req_rd = '0; req_data = '0;
        iss_valid = 1'b0; iss_rd = '0; qa1 = 5'd3; qa2 = 5'd0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        m_last = NREQ - 1; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset holds ready low even with every requester valid.
        step("rst0");
        step("rst1");
        check("rst.waddr", 32'(waddr), 32'd0);
        check("rst.wdata", wdata, 32'd0);

        // All valid: expect grants 0,1,2,0.
        rst = 1'b0;
        set_req(0, 5'd1, 32'hA0A0_0001);
        set_req(1, 5'd2, 32'hB0B0_0002);
        set_req(2, 5'd3, 32'hC0C0_0003);
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("rr%0d", k), 32'(req_ready), 32'(rr_exp[k]));
            step($sformatf("rr_step%0d", k));
            #1 check($sformatf("rr_wen%0d", k), 32'(wen), 32'd1);
        end
        req_valid = '0;
        step("idle0");
        #1 check("idle.wen", 32'(wen), 32'd0);

        // LSU write of x5.
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        step("lsu5");
        req_valid = '0;
        #1 check("lsu5.wen", 32'(wen), 32'd1);
        check("lsu5.waddr", 32'(waddr), 32'd5);
        check("lsu5.wdata", wdata, 32'hDEAD_BEEF);
        step("lsu5_commit");
        check("rf.x5", rf[5], 32'hDEAD_BEEF);

        // Hazard on x7 until its write commits.
        iss_valid = 1'b1; iss_rd = 5'd7; qa1 = 5'd0;
        step("iss7");
        iss_valid = 1'b0; qa1 = 5'd7;
        #1 check("stall7.a", 32'(stall), 32'd1);
        step("s7a");
        set_req(1, 5'd7, 32'h0000_0077);
        #1 check("stall7.b", 32'(stall), 32'd1);
        step("wr7");
        req_valid = '0;
        #1 check("stall7.c", 32'(stall), 32'd1);
        step("commit7");
        #1 check("stall7.clr", 32'(stall), 32'd0);
        step("s7d");

        // Re-issue of x9 on the edge its old write commits keeps it busy.
        qa1 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        step("iss9");
        iss_valid = 1'b0;
        set_req(2, 5'd9, 32'h0000_0099);
        step("wr9");
        req_valid = '0; iss_valid = 1'b1; iss_rd = 5'd9; qa2 = 5'd9;
        #1 check("same9.wen", 32'(wen), 32'd1);
        check("same9.waddr", 32'(waddr), 32'd9);
        step("same9");
        iss_valid = 1'b0;
        #1 check("stall9.a", 32'(stall), 32'd1);
        step("s9a");
        #1 check("stall9.b", 32'(stall), 32'd1);
        set_req(2, 5'd9, 32'h0000_0999);
        step("wr9b");
        req_valid = '0;
        step("commit9b");
        qa2 = 5'd0;

        // Writes and issues to x0.
        set_req(0, 5'd0, 32'h0000_1234);
        #1 check("x0.ready", 32'(req_ready), 32'b001);
        step("x0req");
        req_valid = '0;
        #1 check("x0.wen", 32'(wen), 32'd0);
        step("x0idle");
        iss_valid = 1'b1; iss_rd = 5'd0;
        step("iss0");
        iss_valid = 1'b0; qa1 = 5'd0;
        #1 check("x0.stall", 32'(stall), 32'd0);
        step("x0q");

        // Reset right after a transfer drops the pending write and the scoreboard.
        set_req(1, 5'd3, 32'h0000_0033);
        iss_valid = 1'b1; iss_rd = 5'd4;
        step("prerst");
        req_valid = '0; iss_valid = 1'b0; rst = 1'b1; qa1 = 5'd4;
        #1 check("prerst.wen", 32'(wen), 32'd1);
        step("midrst");
        rst = 1'b0;
        req_valid = '1;
        #1 check("postrst.wen", 32'(wen), 32'd0);
        check("postrst.ready", 32'(req_ready), 32'b001);
        check("postrst.stall", 32'(stall), 32'd0);
        step("postrst");
        req_valid = '0;
        for (int r = 1; r < 32; r++) begin
            qa1 = 5'(r);
            step($sformatf("busy%0d", r));
        end

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_rd[i*5 +: 5]     = 5'($urandom_range(0, 9));
                req_data[i*32 +: 32] = $urandom;
            end
            iss_valid = 1'($urandom);
            iss_rd    = 5'($urandom_range(0, 9));
            qa1       = 5'($urandom_range(0, 9));
            qa2       = 5'($urandom_range(0, 9));
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
